// File: rtl/va_ovc_state_pkg.sv
// Shared constants for the VC allocator output-VC state tracker.
//   V          : VCs per port
//   N          : router port count
//   ovc_state_e: per-output-VC allocation state (2-bit encoding)
//   multi_hot  : true when more than one bit of a VC vector is set
package va_ovc_state_pkg;

    localparam int unsigned V = 4;
    localparam int unsigned N = 5;

    typedef enum logic [1:0] {
        OVC_IDLE   = 2'd0,
        OVC_ACTIVE = 2'd1,
        OVC_DRAIN  = 2'd2
    } ovc_state_e;

    function automatic logic multi_hot(input logic [V-1:0] vec);
        return (vec & (vec - V'(1))) != '0;
    endfunction

endpackage

// File: rtl/va_ovc_state_unit.sv
// One output VC: allocation FSM, downstream credit counter, error term.
//   clk, rstn         : clock, async active-low reset
//   grant             : allocator granted this VC
//   grant_block       : grant vector was multi-hot, so this grant is ignored
//   sent, tail        : flit (and tail marker) left on this VC
//   sent_block        : send vector was multi-hot, so this send is ignored
//   credit            : one credit returned from downstream
//   avail             : registered, VC is IDLE
//   credit_avail      : registered, credit count nonzero
//   err_c             : combinational protocol-violation term for this VC
module ovc_state_unit
    import va_ovc_state_pkg::*;
#(
    parameter int unsigned BUF_DEPTH = 4
) (
    input  logic clk,
    input  logic rstn,
    input  logic grant,
    input  logic grant_block,
    input  logic sent,
    input  logic sent_block,
    input  logic tail,
    input  logic credit,
    output logic avail,
    output logic credit_avail,
    output logic err_c
);

    localparam int unsigned CW = $clog2(BUF_DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(BUF_DEPTH);

    ovc_state_e    state, state_next;
    logic [CW-1:0] count, count_next;
    logic          send_ok, credit_ok;

    // State, count and the registered flags derived from their next values
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state        <= OVC_IDLE;
            count        <= FULL;
            avail        <= 1'b1;
            credit_avail <= 1'b1;
        end else begin
            state        <= state_next;
            count        <= count_next;
            avail        <= (state_next == OVC_IDLE);
            credit_avail <= (count_next != '0);
        end
    end

    // Next state, next count and error detection; illegal events are dropped
    always_comb begin
        state_next = state;
        count_next = count;
        err_c      = 1'b0;

        send_ok   = sent && !sent_block && (state == OVC_ACTIVE) && (count != '0);
        // A credit at a full counter is only legal when a send frees a slot
        credit_ok = credit && ((count != FULL) || send_ok);

        if (grant && (state != OVC_IDLE)) err_c = 1'b1;
        if (sent && (state != OVC_ACTIVE)) err_c = 1'b1;
        if (sent && (count == '0))         err_c = 1'b1;
        if (tail && !sent)                 err_c = 1'b1;
        if (credit && !credit_ok)          err_c = 1'b1;

        if (send_ok && !credit_ok) begin
            count_next = count - CW'(1);
        end else if (!send_ok && credit_ok) begin
            count_next = count + CW'(1);
        end

        case (state)
            OVC_IDLE: begin
                if (grant && !grant_block) state_next = OVC_ACTIVE;
            end
            OVC_ACTIVE: begin
                if (send_ok && tail) state_next = OVC_DRAIN;
            end
            OVC_DRAIN: begin
                // Registered count: drain always spans at least one cycle
                if (count == FULL) state_next = OVC_IDLE;
            end
            default: state_next = OVC_IDLE;
        endcase
    end

endmodule

// File: rtl/va_ovc_state.sv
// Output-VC state tracker for one router output port.
//   clk, rstn       : clock, async active-low reset
//   vcGrant         : one-hot/zero output-VC grant from the allocator
//   flitSent        : one-hot/zero flit departure per VC
//   tailSent        : departing flit is a tail (qualified by flitSent)
//   creditIn        : per-VC credit return from downstream
//   outVCAvailable  : registered, VC j is IDLE
//   creditAvailable : registered, VC j has credit
//   protoErr        : sticky protocol-violation flag, cleared only by reset
module va_ovc_state
    import va_ovc_state_pkg::*;
#(
    parameter int unsigned BUF_DEPTH = 4
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic [V-1:0] vcGrant,
    input  logic [V-1:0] flitSent,
    input  logic [V-1:0] tailSent,
    input  logic [V-1:0] creditIn,
    output logic [V-1:0] outVCAvailable,
    output logic [V-1:0] creditAvailable,
    output logic         protoErr
);

    logic         grant_multi;
    logic         sent_multi;
    logic [V-1:0] vc_err;

    // Multi-hot vectors are errors and void every bit of that vector
    assign grant_multi = multi_hot(vcGrant);
    assign sent_multi  = multi_hot(flitSent);

    for (genvar j = 0; j < V; j++) begin : g_vc
        ovc_state_unit #(
            .BUF_DEPTH (BUF_DEPTH)
        ) u_unit (
            .clk          (clk),
            .rstn         (rstn),
            .grant        (vcGrant[j]),
            .grant_block  (grant_multi),
            .sent         (flitSent[j]),
            .sent_block   (sent_multi),
            .tail         (tailSent[j]),
            .credit       (creditIn[j]),
            .avail        (outVCAvailable[j]),
            .credit_avail (creditAvailable[j]),
            .err_c        (vc_err[j])
        );
    end

    // Sticky error collector
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            protoErr <= 1'b0;
        end else begin
            protoErr <= protoErr | (|vc_err) | grant_multi | sent_multi;
        end
    end

endmodule
